// File: rtl/counter_bank_pkg.sv
// Shared encodings for the counter bank: channel modes, register offsets and the CTRL layout.
package counter_bank_pkg;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;
   localparam logic [1:0] MODE_PWM     = 2'd2;
   localparam logic [1:0] MODE_SQUARE  = 2'd3;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_CMP    = 2'd2;
   localparam logic [1:0] REG_COUNT  = 2'd3;
   localparam logic [1:0] REG_STATUS = 2'd0;

   localparam logic [3:0] GLOBAL_CH = 4'hF;

   typedef struct packed {
      logic       irq_en;
      logic [1:0] mode;
      logic       en;
   } ctrl_t;

endpackage

// File: rtl/counter_bank_ch.sv
// One timer channel: CTRL/LOAD/CMP/COUNT registers, tick edge detect and the mode-dependent output.
module counter_bank_ch
   import counter_bank_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             tick,
   input  logic             ctrl_we,
   input  logic             load_we,
   input  logic             cmp_we,
   input  ctrl_t            ctrl_wdata,
   input  logic [CNT_W-1:0] val_wdata,
   output ctrl_t            ctrl,
   output logic [CNT_W-1:0] load,
   output logic [CNT_W-1:0] cmp,
   output logic [CNT_W-1:0] count,
   output logic             term,
   output logic             out
);

   logic tick_q;
   logic done;
   logic pulse;
   logic sq;
   logic start;
   logic act;
   logic last;

   // Enabling reloads COUNT and swallows any tick landing on the same clock.
   assign start = ctrl_we && ctrl_wdata.en && !ctrl.en;
   assign act   = tick && !tick_q && ctrl.en && !start;
   assign last  = (count <= CNT_W'(1));
   assign term  = act && last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tick_q <= 1'b0;
         ctrl   <= '0;
         load   <= '0;
         cmp    <= '0;
         count  <= '0;
         done   <= 1'b0;
         pulse  <= 1'b0;
         sq     <= 1'b0;
      end else begin
         tick_q <= tick;
         pulse  <= term && (ctrl.mode == MODE_RELOAD);
         if (load_we) load <= val_wdata;
         if (cmp_we)  cmp  <= val_wdata;
         if (start) begin
            count <= load;
            done  <= 1'b0;
         end else if (act) begin
            if (last) begin
               if (ctrl.mode == MODE_ONESHOT) begin
                  count   <= '0;
                  ctrl.en <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  count <= load;
               end
               if (ctrl.mode == MODE_SQUARE) sq <= !sq;
            end else begin
               count <= count - CNT_W'(1);
            end
         end
         if (ctrl_we) ctrl <= ctrl_wdata;
      end
   end

   always_comb begin
      case (ctrl.mode)
         MODE_ONESHOT: out = done;
         MODE_RELOAD:  out = pulse;
         MODE_PWM:     out = (count < cmp);
         default:      out = sq;
      endcase
   end

endmodule

// File: rtl/counter_bank.sv
// N-channel timer/counter bank on the MIO bus: address decode, W1C status, read mux and combined irq.
module counter_bank
   import counter_bank_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NUM_CH-1:0] tick_i,
   input  logic              bus_we,
   input  logic [7:0]        bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   output logic [NUM_CH-1:0] cnt_out,
   output logic              irq
);

   logic [3:0]        ch_sel;
   logic [1:0]        reg_sel;
   ctrl_t             ctrl  [NUM_CH];
   logic [CNT_W-1:0]  load  [NUM_CH];
   logic [CNT_W-1:0]  cmp   [NUM_CH];
   logic [CNT_W-1:0]  count [NUM_CH];
   logic [NUM_CH-1:0] term;
   logic [NUM_CH-1:0] irq_en;
   logic [NUM_CH-1:0] status;
   logic [NUM_CH-1:0] clr;
   logic              unused_ok;

   assign ch_sel    = bus_addr[7:4];
   assign reg_sel   = bus_addr[3:2];
   assign unused_ok = ^{bus_addr[1:0], bus_wdata};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic hit;
      assign hit = bus_we && (ch_sel == 4'(i));

      counter_bank_ch #(.CNT_W(CNT_W)) u_ch (
         .clk        (clk),
         .rstn       (rstn),
         .tick       (tick_i[i]),
         .ctrl_we    (hit && (reg_sel == REG_CTRL)),
         .load_we    (hit && (reg_sel == REG_LOAD)),
         .cmp_we     (hit && (reg_sel == REG_CMP)),
         .ctrl_wdata (ctrl_t'(bus_wdata[3:0])),
         .val_wdata  (bus_wdata[CNT_W-1:0]),
         .ctrl       (ctrl[i]),
         .load       (load[i]),
         .cmp        (cmp[i]),
         .count      (count[i]),
         .term       (term[i]),
         .out        (cnt_out[i])
      );

      assign irq_en[i] = ctrl[i].irq_en;
   end

   assign clr = (bus_we && (ch_sel == GLOBAL_CH) && (reg_sel == REG_STATUS))
                ? bus_wdata[NUM_CH-1:0] : '0;

   // A terminal event beats a clear of the same bit in the same clock.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) status <= '0;
      else       status <= (status & ~clr) | term;
   end

   assign irq = |(status & irq_en);

   always_comb begin
      bus_rdata = '0;
      if (ch_sel == GLOBAL_CH) begin
         if (reg_sel == REG_STATUS) bus_rdata = 32'(status);
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 4'(i)) begin
               case (reg_sel)
                  REG_CTRL: bus_rdata = 32'(ctrl[i]);
                  REG_LOAD: bus_rdata = 32'(load[i]);
                  REG_CMP:  bus_rdata = 32'(cmp[i]);
                  default:  bus_rdata = 32'(count[i]);
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed scenarios plus random traffic against a tick-level model.
module tb_counter_bank;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 32;
   localparam logic [31:0] VMASK = (CNT_W == 32) ? 32'hFFFF_FFFF : 32'((64'd1 << CNT_W) - 64'd1);

   logic              clk;
   logic              rstn;
   logic [NUM_CH-1:0] tick_i;
   logic              bus_we;
   logic [7:0]        bus_addr;
   logic [31:0]       bus_wdata;
   logic [31:0]       bus_rdata;
   logic [NUM_CH-1:0] cnt_out;
   logic              irq;

   counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .tick_i    (tick_i),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .cnt_out   (cnt_out),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference state, one entry per channel
   logic              m_en    [NUM_CH];
   logic [1:0]        m_mode  [NUM_CH];
   logic              m_irqen [NUM_CH];
   logic [31:0]       m_load  [NUM_CH];
   logic [31:0]       m_cmp   [NUM_CH];
   logic [31:0]       m_count [NUM_CH];
   logic              m_done  [NUM_CH];
   logic              m_pulse [NUM_CH];
   logic              m_sq    [NUM_CH];
   logic              m_tq    [NUM_CH];
   logic [NUM_CH-1:0] m_status;
   logic [NUM_CH-1:0] tk_cur;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_en[c] = 0; m_mode[c] = 0; m_irqen[c] = 0; m_load[c] = 0; m_cmp[c] = 0;
         m_count[c] = 0; m_done[c] = 0; m_pulse[c] = 0; m_sq[c] = 0; m_tq[c] = 0;
      end
      m_status = '0;
   endtask

   task automatic model_step(input logic [NUM_CH-1:0] tk, input logic we,
                             input logic [7:0] a, input logic [31:0] d);
      int ch;
      int rg;
      logic [NUM_CH-1:0] fired;
      ch = int'(a[7:4]);
      rg = int'(a[3:2]);
      fired = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         logic rise, wr, start;
         rise  = tk[c] && !m_tq[c];
         wr    = we && (ch == c);
         start = wr && (rg == 0) && d[0] && !m_en[c];
         m_pulse[c] = 1'b0;
         if (start) begin
            m_count[c] = m_load[c];
            m_done[c]  = 1'b0;
         end else if (rise && m_en[c]) begin
            if (m_count[c] <= 1) begin
               fired[c]   = 1'b1;
               m_pulse[c] = (m_mode[c] == 2'd1);
               if (m_mode[c] == 2'd0) begin
                  m_count[c] = 0;
                  m_en[c]    = 1'b0;
                  m_done[c]  = 1'b1;
               end else begin
                  m_count[c] = m_load[c];
               end
               if (m_mode[c] == 2'd3) m_sq[c] = !m_sq[c];
            end else begin
               m_count[c] = m_count[c] - 1;
            end
         end
         m_tq[c] = tk[c];
         if (wr) begin
            case (rg)
               0: begin m_en[c] = d[0]; m_mode[c] = d[2:1]; m_irqen[c] = d[3]; end
               1: m_load[c] = d & VMASK;
               2: m_cmp[c]  = d & VMASK;
               default: ;
            endcase
         end
      end
      if (we && ch == 15 && rg == 0) m_status = m_status & ~d[NUM_CH-1:0];
      m_status = m_status | fired;
   endtask

   function automatic logic exp_out(input int c);
      case (m_mode[c])
         2'd0:    return m_done[c];
         2'd1:    return m_pulse[c];
         2'd2:    return m_count[c] < m_cmp[c];
         default: return m_sq[c];
      endcase
   endfunction

   function automatic logic exp_irq();
      logic r;
      r = 1'b0;
      for (int c = 0; c < NUM_CH; c++) r = r | (m_status[c] & m_irqen[c]);
      return r;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [7:0] a);
      int ch;
      ch = int'(a[7:4]);
      if (ch == 15) return (a[3:2] == 2'd0) ? 32'(m_status) : 32'd0;
      if (ch >= NUM_CH) return 32'd0;
      case (a[3:2])
         2'd0:    return {28'd0, m_irqen[ch], m_mode[ch], m_en[ch]};
         2'd1:    return m_load[ch];
         2'd2:    return m_cmp[ch];
         default: return m_count[ch];
      endcase
   endfunction

   // one clock: apply inputs, advance the model, then compare outputs and one register read
   task automatic step(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [7:0] ra);
      tick_i = tk_cur; bus_we = we; bus_addr = a; bus_wdata = d;
      @(posedge clk);
      model_step(tk_cur, we, a, d);
      #1;
      for (int c = 0; c < NUM_CH; c++) check("cnt_out", 32'(cnt_out[c]), 32'(exp_out(c)));
      check("irq", 32'(irq), 32'(exp_irq()));
      bus_we = 1'b0; bus_addr = ra;
      #1;
      check("rdata", bus_rdata, exp_rd(ra));
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      step(1'b1, a, d, a);
   endtask

   task automatic idle(input int n, input logic [7:0] ra);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 32'd0, ra);
   endtask

   task automatic tk(input int c);
      logic [7:0] ra;
      ra = {4'(c), 2'd3, 2'd0};
      tk_cur[c] = 1'b1; step(1'b0, 8'h00, 32'd0, ra);
      tk_cur[c] = 1'b0; step(1'b0, 8'h00, 32'd0, ra);
   endtask

   task automatic peek(input string tag, input logic [7:0] a, input logic [31:0] exp);
      bus_addr = a;
      #1;
      check(tag, bus_rdata, exp);
   endtask

   initial begin
      rstn = 1'b0; tick_i = '0; tk_cur = '0;
      bus_we = 1'b0; bus_addr = 8'h0C; bus_wdata = '0;
      model_reset();
      #2;
      check("rst_cnt_out", 32'(cnt_out), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", bus_rdata, 32'd0);
      #6 rstn = 1'b1;

      // reload period 4, tick every 8 clocks
      wr(8'h04, 32'd4);
      wr(8'h00, 32'h0B);
      for (int k = 1; k <= 12; k++) begin
         tk_cur[0] = 1'b1; step(1'b0, 8'h00, 32'd0, 8'h0C);
         check("t1_pulse", 32'(cnt_out[0]), (k % 4 == 0) ? 32'd1 : 32'd0);
         tk_cur[0] = 1'b0; step(1'b0, 8'h00, 32'd0, 8'hF0);
         check("t1_pulse_w", 32'(cnt_out[0]), 32'd0);
         idle(6, 8'h0C);
      end
      check("t1_irq_set", 32'(irq), 32'd1);
      wr(8'hF0, 32'h1);
      check("t1_irq_clr", 32'(irq), 32'd0);

      // one-shot on ch1
      wr(8'h14, 32'd3);
      wr(8'h10, 32'h01);
      for (int k = 0; k < 3; k++) tk(1);
      peek("t2_count", 8'h1C, 32'd0);
      peek("t2_ctrl", 8'h10, 32'd0);
      check("t2_out", 32'(cnt_out[1]), 32'd1);
      tk(1); tk(1);
      peek("t2_count_hold", 8'h1C, 32'd0);
      check("t2_out_hold", 32'(cnt_out[1]), 32'd1);
      wr(8'h10, 32'h01);
      check("t2_out_clr", 32'(cnt_out[1]), 32'd0);
      peek("t2_reload", 8'h1C, 32'd3);

      // PWM on ch2
      wr(8'h24, 32'd10);
      wr(8'h28, 32'd3);
      wr(8'h20, 32'h05);
      for (int k = 0; k < 20; k++) tk(2);
      wr(8'h28, 32'd0);
      for (int k = 0; k < 10; k++) begin tk(2); check("t3_cmp0", 32'(cnt_out[2]), 32'd0); end
      wr(8'h28, 32'd11);
      for (int k = 0; k < 10; k++) begin tk(2); check("t3_cmp11", 32'(cnt_out[2]), 32'd1); end

      // enable colliding with a tick
      wr(8'h20, 32'h04);
      wr(8'h24, 32'd5);
      tk_cur[2] = 1'b1; step(1'b1, 8'h20, 32'h05, 8'h2C);
      check("t4_en_tick", bus_rdata, 32'd5);
      tk_cur[2] = 1'b0; idle(1, 8'h2C);

      // terminal event colliding with W1C
      wr(8'h04, 32'd1);
      wr(8'h00, 32'h0A);
      wr(8'h00, 32'h0B);
      tk_cur[0] = 1'b1; step(1'b1, 8'hF0, 32'h1, 8'hF0);
      check("t4_w1c", 32'(bus_rdata[0]), 32'd1);
      tk_cur[0] = 1'b0; idle(1, 8'hF0);
      wr(8'hF0, 32'h7);

      // LOAD change mid-run
      wr(8'h04, 32'd8);
      wr(8'h00, 32'h0A);
      wr(8'h00, 32'h0B);
      peek("t5_start", 8'h0C, 32'd8);
      tk(0); tk(0); tk(0);
      peek("t5_mid", 8'h0C, 32'd5);
      wr(8'h04, 32'd2);
      begin
         logic [31:0] seq [7];
         seq = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2};
         for (int k = 0; k < 7; k++) begin
            tk(0);
            peek("t5_seq", 8'h0C, seq[k]);
         end
      end

      // asynchronous reset between edges
      check("t6_pre_irq", 32'(irq), 32'd1);
      idle(1, 8'h0C);
      #2 rstn = 1'b0;
      #1;
      check("t6_cnt_out", 32'(cnt_out), 32'd0);
      check("t6_irq", 32'(irq), 32'd0);
      peek("t6_count", 8'h0C, 32'd0);
      peek("t6_status", 8'hF0, 32'd0);
      model_reset();
      rstn = 1'b1;
      peek("t6_ctrl", 8'h00, 32'd0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         logic       we;
         logic [7:0] a, ra;
         logic [31:0] d;
         tk_cur = NUM_CH'($urandom);
         we = ($urandom_range(0, 3) == 0);
         a  = {4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom)};
         if ($urandom_range(0, 3) != 0) a[7:4] = 4'($urandom_range(0, NUM_CH - 1));
         d = $urandom;
         if (a[7:4] != 4'hF && (a[3:2] == 2'd1 || a[3:2] == 2'd2)) d = $urandom_range(0, 12);
         ra = {4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom)};
         if ($urandom_range(0, 2) != 0) ra[7:4] = 4'($urandom_range(0, NUM_CH - 1));
         step(we, a, d, ra);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
